// File: rtl/load_byte_assembler_pkg.sv
// Shared encodings for the byte-wide load engine: size codes, mux selects,
// FSM states and small decode helpers.
package load_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE    = 2'b00,
        SIZE_HALF    = 2'b01,
        SIZE_WORD    = 2'b10,
        SIZE_ILLEGAL = 2'b11
    } size_e;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_LAST,
        ST_DONE
    } state_e;

    // Number of bytes moved for a size code; 0 marks a rejected request.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_bytes = 3'd1;
            SIZE_HALF: size_bytes = 3'd2;
            SIZE_WORD: size_bytes = 3'd4;
            default:   size_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] size_sel(input logic [1:0] size);
        case (size)
            SIZE_BYTE: size_sel = SEL_BYTE;
            SIZE_HALF: size_sel = SEL_HALF;
            default:   size_sel = SEL_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
        case (size)
            SIZE_HALF: misaligned = lsb[0];
            SIZE_WORD: misaligned = (lsb != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_byte_assembler_if.sv
// Request/result bus plus byte-memory port of the load engine.
// slave: the load engine; master: requester and memory model.
interface load_byte_assembler_if #(
    parameter int ADDR_W = 16
);
    logic              start;
    logic [1:0]        size;
    logic [ADDR_W-1:0] addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       data_word;
    logic [15:0]       data_half;
    logic [7:0]        data_byte;
    logic [1:0]        sel;

    modport slave (
        input  start, size, addr, mem_data,
        output mem_rd, mem_addr, busy, done, err,
               data_word, data_half, data_byte, sel
    );

    modport master (
        output start, size, addr, mem_data,
        input  mem_rd, mem_addr, busy, done, err,
               data_word, data_half, data_byte, sel
    );
endinterface

// File: rtl/load_byte_assembler_byte_lane_insert.sv
// Replaces one byte lane of a 32-bit word; kept separate so a store path
// can reuse the same lane steering.
module byte_lane_insert (
    input  logic [31:0] word_i,
    input  logic [1:0]  lane_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o
);
    always_comb begin
        word_o = word_i;
        case (lane_i)
            2'd0:    word_o[7:0]   = byte_i;
            2'd1:    word_o[15:8]  = byte_i;
            2'd2:    word_o[23:16] = byte_i;
            default: word_o[31:24] = byte_i;
        endcase
    end
endmodule

// File: rtl/load_byte_assembler.sv
// Multi-cycle little-endian load of 1/2/4 bytes from a byte-wide synchronous
// memory. Optional macro LOAD_ALIGN_CHECK_EN rejects misaligned half/word loads.
module load_byte_assembler
    import load_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    load_byte_assembler_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q;
    logic [2:0]        n_q;
    logic [1:0]        cnt_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_rd_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        sel_q;
    logic [31:0]       word_q;

    logic              reject;
    logic [1:0]        lane;
    logic [31:0]       word_d;

`ifdef LOAD_ALIGN_CHECK_EN
    always_comb begin
        reject = (bus.size == SIZE_ILLEGAL) || misaligned(bus.size, bus.addr[1:0]);
    end
`else
    always_comb begin
        reject = (bus.size == SIZE_ILLEGAL);
    end
`endif

    // Data for the read issued in the previous cycle lands in lane cnt-1;
    // in LAST it is the final lane N-1.
    always_comb begin
        lane = cnt_q - 2'd1;
        if (state_q == ST_LAST) begin
            lane = 2'(n_q - 3'd1);
        end
    end

    byte_lane_insert u_lane (
        .word_i (word_q),
        .lane_i (lane),
        .byte_i (bus.mem_data),
        .word_o (word_d)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            n_q        <= 3'd0;
            cnt_q      <= 2'd0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            sel_q      <= SEL_WORD;
            word_q     <= 32'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        word_q <= 32'd0;
                        busy_q <= 1'b1;
                        cnt_q  <= 2'd0;
                        if (reject) begin
                            // Rejected loads idle one cycle in LAST so that
                            // done still arrives N+2 cycles after start (N=0).
                            n_q     <= 3'd0;
                            sel_q   <= SEL_WORD;
                            state_q <= ST_LAST;
                        end else begin
                            n_q        <= size_bytes(bus.size);
                            sel_q      <= size_sel(bus.size);
                            mem_addr_q <= bus.addr;
                            mem_rd_q   <= 1'b1;
                            state_q    <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (cnt_q != 2'd0) begin
                        word_q <= word_d;
                    end
                    if (3'(cnt_q) == n_q - 3'd1) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= ST_LAST;
                    end else begin
                        cnt_q      <= cnt_q + 2'd1;
                        mem_addr_q <= mem_addr_q + ADDR_ONE;
                    end
                end
                ST_LAST: begin
                    if (n_q != 3'd0) begin
                        word_q <= word_d;
                    end
                    cnt_q   <= 2'd0;
                    done_q  <= 1'b1;
                    err_q   <= (n_q == 3'd0);
                    state_q <= ST_DONE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.sel       = sel_q;
    assign bus.data_word = word_q;
    assign bus.data_half = word_q[15:0];
    assign bus.data_byte = word_q[7:0];

endmodule
